gcd_arbiter: RTL and testbench

//  Shares one subtraction-based GCD engine between N_REQ requesters.

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_engine.sv | 43 ++++
 rtl/gcd_arbiter.sv | 158 +++++++++++++++
 tb/tb_gcd_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the round-robin GCD arbiter and its datapath.
// Optional build macro (used by gcd_arbiter): GCD_ARB_ZERO_ERR_EN.
package gcd_pkg;

    // Controller states; encoding is fixed so it can be probed externally.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Default operand width and requester count.
    localparam int GCD_WIDTH = 8;
    localparam int GCD_NREQ  = 4;

endpackage

// File: rtl/gcd_engine.sv
// Subtraction-based GCD datapath: loads an operand pair, then repeatedly
// subtracts the smaller operand from the larger one until the pair is equal
// or one side is zero. The controller decides when to load and when to step.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             term,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    // Termination test and result: with one side zero, x|y yields the other
    // side; with both equal, x|y is that common value.
    always_comb begin
        term   = (x == y) || (x == '0) || (y == '0);
        result = x | y;
    end

    // Operand registers: load on accept, otherwise one subtraction per step.
    // The larger operand is always the minuend, so no underflow is possible.
    always_ff @(posedge clk) begin
        if (load) begin
            x <= a;
            y <= b;
        end else if (step && !term) begin
            if (x > y) begin
                x <= x - y;
            end else begin
                y <= y - x;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one gcd_engine among N_REQ requesters.
// One job is in flight at a time; the answer is returned on a shared
// response bus together with a one-hot ack pulse for the owner.
// Optional build macro: GCD_ARB_ZERO_ERR_EN adds rsp_err, flagging jobs
// that arrived with a zero operand (those then answer rsp_gcd=0).
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int N_REQ = GCD_NREQ,
    parameter int WIDTH = GCD_WIDTH,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       ack,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_gcd,
    output logic                   busy
`ifdef GCD_ARB_ZERO_ERR_EN
    ,
    output logic                   rsp_err
`endif
);

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id;
    logic [ID_W-1:0]  grant_id;
    logic             any_req;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             eng_load;
    logic             eng_step;
    logic             term;
    logic [WIDTH-1:0] result;
`ifdef GCD_ARB_ZERO_ERR_EN
    logic             zero_job;
`endif

    // First requester with req set, scanning upward from ptr and wrapping.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && r[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Successor index modulo N_REQ (N_REQ need not be a power of two).
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (int'(v) == N_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] v);
        logic [N_REQ-1:0] sel;
        sel    = '0;
        sel[v] = 1'b1;
        return sel;
    endfunction

    // Arbitration and operand steering for the candidate grant.
    always_comb begin
        any_req  = |req;
        grant_id = rr_pick(req, rr_ptr);
        a_sel    = a_in[grant_id*WIDTH +: WIDTH];
        b_sel    = b_in[grant_id*WIDTH +: WIDTH];
        eng_load = (state == IDLE) && any_req;
        eng_step = (state == RUN);
    end

    gcd_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk    (clk),
        .load   (eng_load),
        .step   (eng_step),
        .a      (a_sel),
        .b      (b_sel),
        .term   (term),
        .result (result)
    );

    // Controller: IDLE accepts a job, RUN iterates until the engine reports
    // termination, DONE presents the registered response for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id        <= '0;
            ack       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_gcd   <= '0;
            busy      <= 1'b0;
`ifdef GCD_ARB_ZERO_ERR_EN
            zero_job  <= 1'b0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack       <= '0;
                    rsp_valid <= 1'b0;
                    if (any_req) begin
                        id    <= grant_id;
                        state <= RUN;
                        busy  <= 1'b1;
`ifdef GCD_ARB_ZERO_ERR_EN
                        zero_job <= (a_sel == '0) || (b_sel == '0);
`endif
                    end
                end
                RUN: begin
                    if (term) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        ack       <= onehot(id);
                        rsp_id    <= id;
`ifdef GCD_ARB_ZERO_ERR_EN
                        rsp_gcd   <= zero_job ? '0 : result;
                        rsp_err   <= zero_job;
`else
                        rsp_gcd   <= result;
`endif
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    ack       <= '0;
                    busy      <= 1'b0;
                    rr_ptr    <= wrap_inc(id);
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    ack       <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: table of single jobs with latency,
// plus hand-written round-robin, operand-change and mid-job reset sequences.
module tb_gcd_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   ack;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_gcd;
    logic           busy;
`ifdef GCD_ARB_ZERO_ERR_EN
    logic           rsp_err;
`endif

    gcd_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_gcd   (rsp_gcd),
        .busy      (busy)
`ifdef GCD_ARB_ZERO_ERR_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    typedef struct {
        int         id;
        logic [W-1:0] gcd;
        logic       err;
        int         acc;
        int         lat;
        bit         chk_lat;
    } exp_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] gcd;
        int           lat;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[12];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] g, input int acc, input int lat, input bit chk);
        exp_t e;
        e.id      = id;
        e.gcd     = g;
        e.err     = 1'b0;
`ifdef GCD_ARB_ZERO_ERR_EN
        if (a == '0 || b == '0) begin
            e.err = 1'b1;
            e.gcd = '0;
        end
`endif
        e.acc     = acc;
        e.lat     = lat;
        e.chk_lat = chk;
        return e;
    endfunction

    // Response monitor: compares every response against the scoreboard head
    // and checks that ack stays low outside responses.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got id %0d gcd %0d, expected no response", rsp_id, rsp_gcd);
            end else begin
                mon_e = sbq.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                check("rsp_gcd", 32'(rsp_gcd), 32'(mon_e.gcd));
                check("ack_onehot", 32'(ack), 32'(1 << mon_e.id));
`ifdef GCD_ARB_ZERO_ERR_EN
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
`endif
                if (mon_e.chk_lat) check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end else begin
            check("ack_idle", 32'(ack), 32'd0);
        end
    end

    task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[id*W +: W] = a;
        b_in[id*W +: W] = b;
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({"done_", name}, 32'(got), 32'd1);
    endtask

    // Issue one job while the DUT is idle; accept happens on the next edge.
    task automatic run_job(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] g, input int lat, input bit mangle);
        set_ops(id, a, b);
        sbq.push_back(mk(id, a, b, g, cyc + 1, lat, 1'b1));
        req[id] = 1'b1;
        if (mangle) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            set_ops(id, 8'd255, 8'd1);
        end
        wait_valid(400, "job");
        req[id] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{0, 8'd4,   8'd2,   8'd2,  2};
        vecs[1]  = '{1, 8'd5,   8'd3,   8'd1,  4};
        vecs[2]  = '{2, 8'd255, 8'd3,   8'd3,  85};
        vecs[3]  = '{3, 8'd255, 8'd1,   8'd1,  255};
        vecs[4]  = '{0, 8'd7,   8'd1,   8'd1,  7};
        vecs[5]  = '{1, 8'd0,   8'd0,   8'd0,  1};
        vecs[6]  = '{2, 8'd9,   8'd0,   8'd9,  1};
        vecs[7]  = '{3, 8'd0,   8'd5,   8'd5,  1};
        vecs[8]  = '{0, 8'd12,  8'd18,  8'd6,  3};
        vecs[9]  = '{1, 8'd100, 8'd75,  8'd25, 4};
        vecs[10] = '{2, 8'd17,  8'd17,  8'd17, 1};
        vecs[11] = '{3, 8'd1,   8'd255, 8'd1,  255};

        // Reset with every requester asking.
        rst  = 1'b1;
        req  = 4'b1111;
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < N; i++) set_ops(i, W'(i + 10), W'(i + 10));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_gcd", 32'(rsp_gcd), 32'd0);

        // Round robin with all requests held: order 0,1,2,3,0, one idle gap each.
        sbq.push_back(mk(0, 8'd10, 8'd10, 8'd10, 0, 0, 1'b0));
        sbq.push_back(mk(1, 8'd11, 8'd11, 8'd11, 0, 0, 1'b0));
        sbq.push_back(mk(2, 8'd12, 8'd12, 8'd12, 0, 0, 1'b0));
        sbq.push_back(mk(3, 8'd13, 8'd13, 8'd13, 0, 0, 1'b0));
        sbq.push_back(mk(0, 8'd10, 8'd10, 8'd10, 0, 0, 1'b0));
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            wait_valid(50, "rr");
            if (j == 4) req = '0;
            @(negedge clk);
            check("rr_idle_gap", 32'(busy), 32'd0);
            if (j != 4) begin
                @(negedge clk);
                check("rr_regrant", 32'(busy), 32'd1);
            end
        end

        // Table of single jobs with exact latency.
        for (int v = 0; v < 12; v++) begin
            run_job(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].gcd, vecs[v].lat, 1'b0);
        end

        // Operands changed during RUN must not affect the result.
        run_job(1, 8'd20, 8'd8, 8'd4, 4, 1'b1);
        // Leaves the round-robin pointer at 3.
        run_job(2, 8'd6, 8'd4, 8'd2, 3, 1'b0);

        // Reset in the middle of a long job: no response, pointer back to 0.
        set_ops(1, 8'd255, 8'd1);
        req = 4'b0010;
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("run_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        req = '0;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_gcd", 32'(rsp_gcd), 32'd0);
        rst = 1'b0;
        repeat (300) @(negedge clk);

        set_ops(0, 8'd33, 8'd33);
        set_ops(3, 8'd48, 8'd48);
        sbq.push_back(mk(0, 8'd33, 8'd33, 8'd33, 0, 0, 1'b0));
        sbq.push_back(mk(3, 8'd48, 8'd48, 8'd48, 0, 0, 1'b0));
        req = 4'b1001;
        wait_valid(50, "post_rst_a");
        req = req & ~ack;
        wait_valid(50, "post_rst_b");
        req = req & ~ack;

        repeat (4) begin
            @(posedge clk); #1;
        end
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
